// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and constants for the signed divider
package divider_pkg;

    localparam int WIDTH  = 8;
    localparam int N_ITER = 8;

    localparam logic [WIDTH-1:0] OVF_DIVIDEND = 8'h80;
    localparam logic [WIDTH-1:0] OVF_DIVISOR  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_N = 3'd1,
        ST_WAIT_D = 3'd2,
        ST_PREP   = 3'd3,
        ST_ITER   = 3'd4,
        ST_FIX    = 3'd5,
        ST_DONE   = 3'd6
    } div_state_t;

    // Two's complement magnitude; 0x80 maps to itself, read as unsigned 128.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration, purely combinational
module div_step
    import divider_pkg::*;
(
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] md,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [2*WIDTH:0] rq_sh;
    logic [WIDTH:0]   t;

    always_comb begin
        rq_sh  = {r, q} << 1;
        t      = rq_sh[2*WIDTH:WIDTH] - {1'b0, md};
        r_next = rq_sh[2*WIDTH:WIDTH];
        q_next = rq_sh[WIDTH-1:0];
        if (!t[WIDTH]) begin
            r_next    = t;
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/signed_divider8.sv
// rtl/signed_divider8.sv - 8-bit signed restoring divider with go/sw operand entry
module signed_divider8
    import divider_pkg::*;
#(
    parameter int DW = divider_pkg::WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic [DW-1:0] sw,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          busy,
    output logic          over,
    output logic          div_by_zero,
    output logic          ovf
);

    localparam int               CNT_W     = $clog2(N_ITER);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    div_state_t       state;
    logic [DW-1:0]    dividend;
    logic [DW-1:0]    divisor;
    logic [DW-1:0]    md;
    logic [DW-1:0]    q;
    logic [DW:0]      r;
    logic [CNT_W-1:0] cnt;
    logic             sn;
    logic             sd;
    logic             dz;
    logic [DW:0]      r_next;
    logic [DW-1:0]    q_next;

    div_step u_step (
        .r      (r),
        .q      (q),
        .md     (md),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            dividend    <= '0;
            divisor     <= '0;
            md          <= '0;
            q           <= '0;
            r           <= '0;
            cnt         <= '0;
            sn          <= 1'b0;
            sd          <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            over        <= 1'b0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state       <= ST_LOAD_N;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        ovf         <= 1'b0;
                    end
                end
                ST_LOAD_N: begin
                    dividend <= sw;
                    if (!go) begin
                        state <= ST_WAIT_D;
                    end
                end
                ST_WAIT_D: begin
                    if (go) begin
                        divisor <= sw;
                        busy    <= 1'b1;
                        state   <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    sn    <= dividend[DW-1];
                    sd    <= divisor[DW-1];
                    md    <= magnitude(divisor);
                    q     <= magnitude(dividend);
                    r     <= '0;
                    cnt   <= '0;
                    dz    <= (divisor == '0);
                    state <= (divisor == '0) ? ST_FIX : ST_ITER;
                end
                ST_ITER: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (dz) begin
                        quotient    <= '0;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (dividend == OVF_DIVIDEND && divisor == OVF_DIVISOR) begin
                        // -128 / -1 has no 8-bit quotient; report the wrapped value
                        quotient  <= OVF_DIVIDEND;
                        remainder <= '0;
                        ovf       <= 1'b1;
                    end else begin
                        quotient  <= (sn ^ sd) ? -q : q;
                        remainder <= sn ? -r[DW-1:0] : r[DW-1:0];
                    end
                    busy  <= 1'b0;
                    over  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!go) begin
                        over  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    over  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/signed_divider8.md
# signed_divider8

8-bit signed integer divider: the inverse operation of the Booth multiplier, sharing its switch and `go` operator handshake.
- Operand entry: dividend loaded from `sw`, then divisor loaded from `sw`.
- Arithmetic: an 8-iteration restoring divide on magnitudes, followed by a sign fix-up.
- Results: truncating quotient and remainder, presented until the operator releases `go`.
- Placement: sits beside the multiplier behind the same board-level operand-entry front end.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; only 8 is verified.

Ports (clock and reset first):
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `go` input 1: operator handshake, already synchronized/debounced upstream.
- `sw` input 8: operand data, two's complement.
- `quotient` output 8: signed quotient, truncated toward zero.
- `remainder` output 8: signed remainder; sign of the dividend.
- `busy` output 1: high in PREP, ITER, FIX.
- `over` output 1: high in DONE.
- `div_by_zero` output 1: divisor was 0.
- `ovf` output 1: the quotient overflowed (-128 / -1).

## Operation
States: IDLE, LOAD_N, WAIT_D, PREP, ITER, FIX, DONE.

- **IDLE**
  - `go`=1 → LOAD_N.
  - On this transition, clear `quotient`, `remainder`, `div_by_zero` and `ovf`.
- **LOAD_N**
  - Dividend register follows `sw` every cycle.
  - `go`=0 → WAIT_D; the dividend is frozen at the value of `sw` sampled on that edge.
- **WAIT_D**
  - `go`=1 → PREP; capture `sw` as the divisor on that edge.
- **PREP**
  - Record the signs: `sn` = dividend[7], `sd` = divisor[7].
  - Magnitudes: `mn` = |dividend|, `md` = |divisor|, both 8-bit unsigned; |-128| = 0x80.
  - Clear the 9-bit partial remainder `r`; load `q` = `mn`; iteration count = 0.
  - `md`=0 → FIX with the div-by-zero flag set; otherwise → ITER.
- **ITER** (exactly 8 cycles, one iteration per cycle)
  - Shift: `{r,q}` = `{r,q}` << 1.
  - Trial: `t` = `r` − {0,`md`}, computed 9 bits wide.
  - If `t` ≥ 0: `r` = `t` and `q[0]` = 1.
  - After the 8th iteration → FIX.
- **FIX**
  - Div by zero: `quotient`=0, `remainder`=dividend, `div_by_zero`=1.
  - Otherwise:
    - `quotient` = `sn`^`sd` ? −`q` : `q`.
    - `remainder` = `sn` ? −`r[7:0]` : `r[7:0]`.
    - `ovf` = (dividend==0x80 && divisor==0xFF).
    - On overflow, `quotient` = 0x80 (wrapped) and `remainder` = 0.
  - → DONE.
- **DONE**
  - `go`=0 → IDLE.
  - Results hold until the next IDLE→LOAD_N transition.

Arithmetic:
- Internal subtraction is 9-bit; negation is two's complement, mod 2^8.
- Result identity: dividend = quotient·divisor + remainder, exact except in the `ovf` case.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - Dividend, divisor, `r`, `q` and count all 0.
- Reset mid-operation: any state returns to IDLE asynchronously.
  - Outputs clear immediately; no partial result remains visible.
- Latency:
  - Let the divisor be captured on edge k.
  - Normal case: PREP at k, ITER k+1..k+8, FIX k+9, DONE from edge k+10. `over` rises 10 cycles after the capture edge.
  - Div by zero: PREP at k, FIX at k+1; `over` rises from edge k+2.
- `busy` and `over` are never high together.
- `go` changes during PREP, ITER or FIX are ignored; the operation always completes.
- `go` still high on reaching DONE: stay in DONE until it falls.
- `go` held high throughout LOAD_N: no timeout; the dividend keeps tracking `sw`.
- Single-cycle `go` pulse in IDLE: enters LOAD_N, then WAIT_D on the next edge. Legal behaviour.

## Structure
Shared package `divider_pkg` holds:
- The state enum (encoded state constants, one-hot-capable).
- `WIDTH` = 8.
- `N_ITER` = 8.
- `OVF_DIVIDEND` = 8'h80.
- `OVF_DIVISOR` = 8'hFF.

Sub-module:
- `div_step`: purely combinational, one restoring iteration.
- Inputs `r[8:0]`, `q[7:0]`, `md[7:0]`; outputs the next `r` and next `q`.
- Instantiated once, in ITER.

Top level holds the FSM, the operand registers, the counter and the FIX logic.

## Test plan
- 100 / 7 (0x64, 0x07) → `quotient`=0x0E, `remainder`=0x02; `over` high exactly 10 cycles after the divisor capture edge.
- −100 / 7 (0x9C, 0x07) → `quotient`=0xF2 (−14), `remainder`=0xFE (−2). Also 100 / −7 → `quotient`=0xF2, `remainder`=0x02.
- −128 / −1 (0x80, 0xFF) → `quotient`=0x80, `remainder`=0x00, `ovf`=1. Also −128 / 1 → `quotient`=0x80, `ovf`=0.
- 5 / 0 → `div_by_zero`=1, `quotient`=0x00, `remainder`=0x05; `over` 2 cycles after the capture edge.
- Handshake sequence:
  - Toggle `sw` while in LOAD_N; the dividend is the value present on the `go`-falling edge.
  - Toggle `go` during ITER: no effect.
  - Hold `go` high in DONE: stays in DONE.
  - Release `go`: IDLE; outputs retained until the next `go`.
- Assert `rst_n`=0 during the 4th ITER cycle → all outputs 0 immediately. After release, a fresh 127 / 3 completes with `quotient`=0x2A, `remainder`=0x01.
